// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM encoding and register-field constants.
package hazard_ctrl_pkg;

  localparam int unsigned REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_MULTI = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_loaduse_cmp.sv
// Load-use comparator: flags an ID source register that matches a pending load
// destination sitting in the ID/EX register. Purely combinational.
module hazard_loaduse_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              loaduse
);

  // Register zero is hard-wired, so a load targeting it never creates a dependency.
  always_comb begin
    loaduse = ex_memread && (ex_rt != REG_ZERO) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: produces PC / IF/ID / ID/EX write enables and
// flushes for load-use bubbles, EX redirects and multi-cycle EX holds, and
// counts stalled cycles in a saturating counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULTI_CYCLES = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned PERF_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_redirect,
  input  logic              ex_multi,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_reset,
  output logic              id_ex_write,
  output logic              id_ex_reset,
  output logic              busy,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MULTI_CYCLES > 1) ? MULTI_CYCLES - 2 : 0);
  localparam bit               MULTI_EN = (MULTI_CYCLES > 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PERF_W-1:0] stall_q, stall_d;
  logic              loaduse;

  hazard_loaduse_cmp u_loaduse_cmp (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .loaduse    (loaduse)
  );

  assign stall_cycles = stall_q;

  // Next-state, counter and control outputs; all controls act in the cycle the condition is seen.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves a latch behind.
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_reset = 1'b0;
    id_ex_write = 1'b0;
    id_ex_reset = 1'b0;
    busy        = 1'b0;

    if (reset) begin
      if_id_reset = 1'b1;
      id_ex_reset = 1'b1;
      state_d     = ST_RUN;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ex_redirect) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            id_ex_write = 1'b1;
            if_id_reset = 1'b1;
            id_ex_reset = 1'b1;
          end else if (ex_multi && MULTI_EN) begin
            cnt_d   = CNT_LOAD;
            state_d = ST_MULTI;
          end else if (loaduse) begin
            id_ex_reset = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            id_ex_write = 1'b1;
          end
        end
        ST_MULTI: begin
          busy = 1'b1;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            // Release cycle: the held op leaves EX; only load-use can still stall.
            state_d = ST_RUN;
            if (loaduse) begin
              id_ex_reset = 1'b1;
            end else begin
              pc_write    = 1'b1;
              if_id_write = 1'b1;
              id_ex_write = 1'b1;
            end
          end
        end
        default: state_d = ST_RUN;
      endcase
    end

    stall_d = stall_q;
    if (reset) begin
      stall_d = '0;
    end else if (!pc_write && (stall_q != {PERF_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // State, counter and perf-counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Generates the write-enable and flush (synchronous reset) controls consumed by the IF/ID and ID/EX pipeline registers and by the PC register.
- Detects load-use hazards between the ID stage and the ID/EX register contents.
- Applies taken-branch/jump redirect flushes resolved in EX.
- Holds the pipeline for multi-cycle EX operations using an internal FSM and down-counter.
- Sits between the decode stage and the ID/EX register; its outputs drive those registers' write and reset inputs directly.

Parameters:
- MULTI_CYCLES, 4, total EX-stage cycles of a multi-cycle op. Legal range 1..255; 1 means no stall.
- CNT_W, 8, width of the multi-cycle down-counter.
- PERF_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clock  in  1  system clock, all state updates on its rising edge
- reset  in  1  synchronous, active-high
- id_rs  in  5  RS field of the instruction in ID
- id_rt  in  5  RT field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads RT as a source
- ex_memread  in  1  MemRead output of the ID/EX register
- ex_rt  in  5  RT output of the ID/EX register (load destination)
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle
- ex_multi  in  1  ID/EX holds a multi-cycle op
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID write enable
- if_id_reset  out  1  IF/ID flush
- id_ex_write  out  1  ID/EX write enable
- id_ex_reset  out  1  ID/EX flush (inserts a bubble)
- busy  out  1  FSM is in MULTI
- stall_cycles  out  PERF_W  count of cycles with pc_write=0

Behaviour:
- State is registered (RUN, MULTI); cnt is CNT_W bits, stall_cycles is PERF_W bits.
- All control outputs are combinational from the current state and inputs, so a hazard acts in the same cycle it is detected.

Reset:
- While reset=1: pc_write=0, if_id_write=0, id_ex_write=0, if_id_reset=1, id_ex_reset=1, busy=0.
- On the edge with reset=1: next state RUN, cnt=0, stall_cycles=0.
- Reset asserted in MULTI aborts the multi-cycle hold immediately.

Hazard terms:
- loaduse = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & (ex_rt==id_rt))).

RUN state, fixed priority:
1. ex_redirect:
   - pc_write=1, if_id_reset=1, id_ex_reset=1, write enables=1.
   - Next state RUN.
   - Overrides loaduse and ex_multi.
2. ex_multi & MULTI_CYCLES>1:
   - pc_write=0, if_id_write=0, id_ex_write=0; resets=0.
   - cnt <= MULTI_CYCLES-2; next state MULTI.
3. loaduse:
   - pc_write=0, if_id_write=0, id_ex_reset=1, id_ex_write=0.
   - Exactly one bubble. The next cycle sees ex_memread=0 from the bubble, so the hazard clears with no extra state.
4. Otherwise: pc_write=1, if_id_write=1, id_ex_write=1; resets=0.

MULTI state:
- busy=1.
- cnt!=0: all write enables 0, resets 0, cnt <= cnt-1.
- cnt==0: release cycle. Evaluate the RUN rules 3–4 (loaduse or normal advance); next state RUN.
- ex_redirect and ex_multi are ignored in MULTI. The held EX op is not a branch; ex_redirect=1 in MULTI is a bench assertion failure.
- Total stall for one multi op = MULTI_CYCLES-1 cycles, after which the op leaves EX.
- A back-to-back multi op loaded at release restarts the sequence on its next RUN cycle.

stall_cycles:
- Increments on every non-reset cycle with pc_write=0.
- Saturates at all-ones; no wrap.
- Redirect cycles are not counted.

MULTI_CYCLES=1:
- ex_multi has no effect; the FSM never leaves RUN.

Decomposition:
- Shared pipeline package holds:
  - state encoding constants ST_RUN=0, ST_MULTI=1;
  - REG_ZERO=5'd0;
  - field width constant REG_AW=5.
- One natural sub-module, hazard_loaduse_cmp: the combinational loaduse comparator. It is reused later by forwarding logic.
- Everything else stays in hazard_ctrl.

Test Plan:
1. Reset: hold reset 2 cycles from a random state → pc_write=0, both resets=1, busy=0, stall_cycles=0; on first cycle after release pc_write=1 with all resets 0.
2. Load-use: ex_memread=1, ex_rt=5, id_rs=5 → one cycle of pc_write=0, if_id_write=0, id_ex_reset=1; then with ex_memread=0 → normal advance; stall_cycles=1. Repeat with ex_rt=0 → no stall.
3. RT path: ex_rt=7, id_rt=7, id_uses_rt=0 → no stall; id_uses_rt=1 → one bubble.
4. Multi-cycle with MULTI_CYCLES=4: ex_multi=1 in RUN → 3 cycles of all writes 0 with busy=1 on cycles 2–3; release on cycle 4; stall_cycles += 3.
5. Priority: ex_redirect=1 with loaduse true and ex_multi=1 in the same cycle → flush both registers, pc_write=1, state stays RUN, no stall counted.
6. Reset mid-MULTI (cnt=1) → state RUN on the next cycle, busy=0; drive stall_cycles to 16'hFFFF → remains 16'hFFFF after further stalls.
